// File: rtl/spi_master_fifo.sv
// ============================================================================
// Module      : spi_master_fifo
// Description : SFR-mapped SPI master with TX/RX FIFOs, slave selects,
//               programmable SCK divider and back-to-back burst streaming.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module spi_master_fifo #(
  parameter int          DW         = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter int          NSS        = 4,
  parameter logic [7:0]  BASE       = 8'h02
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           psel_i,
  input  logic           penable_i,
  input  logic           we_i,
  input  logic           re_i,
  input  logic [7:0]     addrd_i,
  input  logic [DW-1:0]  databi_i,
  output logic [DW-1:0]  datab_o,
  output logic           sck_o,
  output logic           mosi_o,
  input  logic           miso_i,
  output logic [NSS-1:0] ssn_o,
  output logic           int_o,
  output logic           spim_busy_o,
  input  logic           es_i
);

  localparam int         AW     = $clog2(FIFO_DEPTH);
  localparam int         CW     = AW + 1;
  localparam int         BW     = $clog2(DW);
  localparam logic [7:0] A_CTRL = BASE;
  localparam logic [7:0] A_STAT = BASE + 8'd1;
  localparam logic [7:0] A_DATA = BASE + 8'd2;
  localparam logic [7:0] A_DIV  = BASE + 8'd3;
  localparam logic [7:0] A_SSEL = BASE + 8'd4;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LEAD, S_TRAIL, S_HOLD} state_e;

  state_e           state_q;
  logic [7:0]       ctrl_q, div_q, cnt_q;
  logic [NSS-1:0]   ssel_q;
  logic             spif_q, wcol_q, rovf_q, int_q, sck_q, sample_q, first_q;
  logic [DW-1:0]    shift_q;
  logic [BW-1:0]    bitcnt_q;
  logic [DW-1:0]    tx_mem_q [FIFO_DEPTH];
  logic [DW-1:0]    rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]    tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [CW-1:0]    tx_cnt_q, rx_cnt_q;

  // Control fields
  logic ie, spe, dord, cpol, cpha, ss_auto;
  assign ie      = ctrl_q[7];
  assign spe     = ctrl_q[6];
  assign dord    = ctrl_q[5];
  assign cpol    = ctrl_q[3];
  assign cpha    = ctrl_q[2];
  assign ss_auto = ctrl_q[1];

  // Bus strobes and FIFO / sequencer events
  logic wr, rd, busy, tick, last_bit, abort, start, frame_end, spif_set, stat_wr;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push_req, tx_push, tx_pop, wcol_set, rx_pop, rx_push, rovf_set;
  logic [DW-1:0] rx_word;

  // Shift one bit into the receive end selected by bit order
  function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] s, input logic b,
                                             input logic lsb_first);
    return lsb_first ? {b, s[DW-1:1]} : {s[DW-2:0], b};
  endfunction

  assign wr          = psel_i & ~penable_i & we_i;
  assign rd          = psel_i & ~penable_i & re_i;
  assign busy        = (state_q != S_IDLE);
  assign tick        = (cnt_q == 8'd0);
  assign last_bit    = (bitcnt_q == BW'(DW - 1));
  assign abort       = busy & ~spe;
  assign tx_empty    = (tx_cnt_q == '0);
  assign tx_full     = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty    = (rx_cnt_q == '0);
  assign rx_full     = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign start       = (state_q == S_IDLE) & spe & ~tx_empty;
  assign frame_end   = ~abort & (state_q == S_TRAIL) & tick & last_bit;
  assign spif_set    = (state_q == S_HOLD) & tick;
  assign stat_wr     = wr & (addrd_i == A_STAT);
  assign tx_pop      = ~abort & (start | (frame_end & ~tx_empty));
  assign tx_push_req = ~abort & wr & (addrd_i == A_DATA);
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign wcol_set    = tx_push_req & ~tx_push;
  assign rx_pop      = ~abort & rd & (addrd_i == A_DATA) & ~rx_empty;
  assign rx_push     = frame_end & (~rx_full | rx_pop);
  assign rovf_set    = frame_end & ~rx_push;
  // Final trailing edge: CPHA=1 samples the line now, CPHA=0 uses the bit caught on the leading edge
  assign rx_word     = shift_in(shift_q, cpha ? miso_i : sample_q, dord);

  assign sck_o       = sck_q;
  assign mosi_o      = dord ? shift_q[0] : shift_q[DW-1];
  assign int_o       = int_q;
  assign spim_busy_o = busy;
  assign ssn_o       = (ss_auto && !busy) ? {NSS{1'b1}} : ~ssel_q;

  // SFR read mux, zero for unmapped addresses
  always_comb begin
    datab_o = '0;
    case (addrd_i)
      A_CTRL:  datab_o[7:0]     = ctrl_q;
      A_STAT:  datab_o[5:0]     = {busy, ~rx_empty, tx_empty, rovf_q, wcol_q, spif_q};
      A_DATA:  if (!rx_empty) datab_o = rx_mem_q[rx_rp_q];
      A_DIV:   datab_o[7:0]     = div_q;
      A_SSEL:  datab_o[NSS-1:0] = ssel_q;
      default: datab_o = '0;
    endcase
  end

  // Registers, FIFOs and the serial sequencer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      ssel_q   <= '0;
      spif_q   <= 1'b0;
      wcol_q   <= 1'b0;
      rovf_q   <= 1'b0;
      int_q    <= 1'b0;
      sck_q    <= 1'b0;
      sample_q <= 1'b0;
      first_q  <= 1'b0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
    end else begin
      int_q <= spif_q & ie & es_i;
      if (wr && addrd_i == A_CTRL) ctrl_q <= databi_i[7:0];
      if (wr && addrd_i == A_DIV)  div_q  <= databi_i[7:0];
      if (wr && addrd_i == A_SSEL && !busy) ssel_q <= databi_i[NSS-1:0];

      if (abort) begin
        // Disabling the block mid-transfer drops everything queued
        state_q  <= S_IDLE;
        sck_q    <= cpol;
        spif_q   <= 1'b0;
        wcol_q   <= 1'b0;
        rovf_q   <= 1'b0;
        tx_wp_q  <= '0;
        tx_rp_q  <= '0;
        rx_wp_q  <= '0;
        rx_rp_q  <= '0;
        tx_cnt_q <= '0;
        rx_cnt_q <= '0;
      end else begin
        spif_q <= spif_set | (spif_q & ~(stat_wr & databi_i[0]));
        wcol_q <= wcol_set | (wcol_q & ~(stat_wr & databi_i[1]));
        rovf_q <= rovf_set | (rovf_q & ~(stat_wr & databi_i[2]));

        if (tx_push) begin
          tx_mem_q[tx_wp_q] <= databi_i;
          tx_wp_q           <= tx_wp_q + AW'(1);
        end
        if (tx_pop) tx_rp_q <= tx_rp_q + AW'(1);
        tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);

        if (rx_push) begin
          rx_mem_q[rx_wp_q] <= rx_word;
          rx_wp_q           <= rx_wp_q + AW'(1);
        end
        if (rx_pop) rx_rp_q <= rx_rp_q + AW'(1);
        rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

        case (state_q)
          S_IDLE: begin
            sck_q <= cpol;
            if (start) begin
              shift_q  <= tx_mem_q[tx_rp_q];
              cnt_q    <= div_q;
              bitcnt_q <= '0;
              first_q  <= 1'b1;
              state_q  <= S_SETUP;
            end
          end
          S_SETUP: begin
            if (tick) begin
              cnt_q   <= div_q;
              state_q <= S_LEAD;
            end else cnt_q <= cnt_q - 8'd1;
          end
          S_LEAD: begin
            if (tick) begin
              cnt_q   <= div_q;
              sck_q   <= ~cpol;
              first_q <= 1'b0;
              if (!cpha) sample_q <= miso_i;
              else if (!first_q) shift_q <= shift_in(shift_q, sample_q, dord);
              state_q <= S_TRAIL;
            end else cnt_q <= cnt_q - 8'd1;
          end
          S_TRAIL: begin
            if (tick) begin
              cnt_q <= div_q;
              sck_q <= cpol;
              if (!cpha) shift_q <= shift_in(shift_q, sample_q, dord);
              else sample_q <= miso_i;
              if (!last_bit) begin
                bitcnt_q <= bitcnt_q + BW'(1);
                state_q  <= S_LEAD;
              end else if (!tx_empty) begin
                // Next queued word starts without a gap under the same select
                shift_q  <= tx_mem_q[tx_rp_q];
                bitcnt_q <= '0;
                first_q  <= 1'b1;
                state_q  <= S_LEAD;
              end else state_q <= S_HOLD;
            end else cnt_q <= cnt_q - 8'd1;
          end
          S_HOLD: begin
            if (tick) state_q <= S_IDLE;
            else cnt_q <= cnt_q - 8'd1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
